tjmono_readout_emu: RTL and testbench

TJMONO_READOUT_EMU -- requirements
Module: tjmono_readout_emu

---
 rtl/tjmono_readout_emu.sv | 107 ++++++++++
 tb/tb_tjmono_readout_emu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tjmono_readout_emu.sv
// tjmono_readout_emu: hit FIFO with freeze/token handshake and a fixed-latency
// 27-bit MSB-first serialiser, emulating the TJ-Monopix readout behaviour.
module tjmono_readout_emu #(
   parameter int DEPTH        = 16,
   parameter int READ_LATENCY = 2
) (
   input  logic       clk40_i,
   input  logic       rst_n_i,
   input  logic       hit_valid_i,
   input  logic [5:0] hit_col_i,
   input  logic [8:0] hit_row_i,
   input  logic [5:0] hit_le_i,
   input  logic [5:0] hit_te_i,
   output logic       hit_ready_o,
   input  logic       freeze_i,
   input  logic       read_i,
   output logic       token_o,
   output logic       data_out_o,
   output logic       busy_o,
   output logic [7:0] drop_cnt_o,
   output logic [7:0] proto_err_cnt_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [4:0] WAIT_INIT = 5'(READ_LATENCY - 2);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT} state_t;
   state_t state_q, state_d;
   logic [26:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0] occ_q, occ_d, frozen_q, frozen_d;
   logic [26:0] sh_q, sh_d;
   logic [4:0] cnt_q, cnt_d;
   logic freeze_q, token_q, token_d;
   logic [7:0] drop_q, perr_q;
   logic start, accept, drop;

   assign hit_ready_o = occ_q < FULL;
   assign start = read_i && token_q && state_q == S_IDLE;
   // a pop frees the slot in the same cycle, so a full buffer still takes the hit
   assign accept = hit_valid_i && (hit_ready_o || start);
   assign drop = hit_valid_i && !accept;
   assign occ_d = occ_q + (AW+1)'(accept) - (AW+1)'(start);
   assign frozen_d = !freeze_i ? '0 : !freeze_q ? occ_q : frozen_q - (AW+1)'(start);
   assign token_d = freeze_i && frozen_d != '0;
   assign token_o = token_q;
   assign drop_cnt_o = drop_q;
   assign proto_err_cnt_o = perr_q;

   always_ff @(posedge clk40_i)
      if (accept) mem[wr_ptr_q] <= {hit_col_i, hit_row_i, hit_le_i, hit_te_i};

   always_ff @(posedge clk40_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         frozen_q <= '0;
         sh_q     <= '0;
         cnt_q    <= '0;
         freeze_q <= 1'b0;
         token_q  <= 1'b0;
         drop_q   <= '0;
         perr_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_q + AW'(accept);
         rd_ptr_q <= rd_ptr_q + AW'(start);
         occ_q    <= occ_d;
         frozen_q <= frozen_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         freeze_q <= freeze_i;
         token_q  <= token_d;
         drop_q   <= drop_q + 8'(drop && drop_q != 8'hff);
         perr_q   <= perr_q + 8'(read_i && !start && perr_q != 8'hff);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      sh_d = sh_q;
      case (state_q)
         S_IDLE: if (start) begin
            sh_d = mem[rd_ptr_q];
            state_d = READ_LATENCY == 1 ? S_SHIFT : S_WAIT;
            cnt_d = READ_LATENCY == 1 ? 5'd26 : WAIT_INIT;
         end
         S_WAIT: begin
            state_d = cnt_q == '0 ? S_SHIFT : S_WAIT;
            cnt_d = cnt_q == '0 ? 5'd26 : cnt_q - 5'd1;
         end
         S_SHIFT: begin
            state_d = cnt_q == '0 ? S_IDLE : S_SHIFT;
            cnt_d = cnt_q - 5'd1;
            sh_d = {sh_q[25:0], 1'b0};
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o = state_q != S_IDLE;
      data_out_o = state_q == S_SHIFT && sh_q[26];
   end
endmodule

// File: tb/tb_tjmono_readout_emu.sv
// tb_tjmono_readout_emu: directed checks of buffering, freeze/token handshake,
// serial timing, protocol errors and reset for two latency settings.
module tb_tjmono_readout_emu;
   logic clk = 1'b0;
   logic rst_n, hit_valid, freeze, read, read1;
   logic [5:0] hit_col, hit_le, hit_te;
   logic [8:0] hit_row;
   logic hit_ready, token, data_out, busy;
   logic hit_ready1, token1, data_out1, busy1;
   logic [7:0] drop_cnt, perr_cnt, drop_cnt1, perr_cnt1;
   logic [26:0] w;
   logic tok;
   int n_cmp = 0, n_err = 0, n;

   always #5 clk = ~clk;

   tjmono_readout_emu dut (
      .clk40_i(clk), .rst_n_i(rst_n), .hit_valid_i(hit_valid), .hit_col_i(hit_col),
      .hit_row_i(hit_row), .hit_le_i(hit_le), .hit_te_i(hit_te), .hit_ready_o(hit_ready),
      .freeze_i(freeze), .read_i(read), .token_o(token), .data_out_o(data_out),
      .busy_o(busy), .drop_cnt_o(drop_cnt), .proto_err_cnt_o(perr_cnt)
   );

   tjmono_readout_emu #(.READ_LATENCY(1)) dut1 (
      .clk40_i(clk), .rst_n_i(rst_n), .hit_valid_i(hit_valid), .hit_col_i(hit_col),
      .hit_row_i(hit_row), .hit_le_i(hit_le), .hit_te_i(hit_te), .hit_ready_o(hit_ready1),
      .freeze_i(freeze), .read_i(read1), .token_o(token1), .data_out_o(data_out1),
      .busy_o(busy1), .drop_cnt_o(drop_cnt1), .proto_err_cnt_o(perr_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [26:0] wd(input int c, input int r, input int l, input int t);
      return {6'(c), 9'(r), 6'(l), 6'(t)};
   endfunction

   task automatic set_hit(input int c, input int r, input int l, input int t);
      hit_col = 6'(c);
      hit_row = 9'(r);
      hit_le = 6'(l);
      hit_te = 6'(t);
   endtask

   task automatic push(input int c, input int r, input int l, input int t);
      set_hit(c, r, l, t);
      hit_valid = 1'b1;
      tick;
      hit_valid = 1'b0;
   endtask

   task automatic set_freeze(input logic f);
      freeze = f;
      tick;
   endtask

   // READ on the main instance; bad_at >= 0 raises READ again at that shift bit
   task automatic read_word(input int bad_at, input logic with_hit, output logic [26:0] wo, output logic to);
      wo = '0;
      hit_valid = with_hit;
      read = 1'b1;
      tick;
      read = 1'b0;
      hit_valid = 1'b0;
      to = token;
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_data", 32'(data_out), 32'd0);
      tick;
      for (int i = 0; i < 27; i++) begin
         wo = {wo[25:0], data_out};
         read = i == bad_at;
         tick;
         read = 1'b0;
      end
      chk("end_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; hit_valid = 1'b0; freeze = 1'b0; read = 1'b0; read1 = 1'b0;
      set_hit(0, 0, 0, 0);
      tick;
      tick;
      chk("rst_token", 32'(token), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(hit_ready), 32'd1);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_perr", 32'(perr_cnt), 32'd0);
      rst_n = 1'b1;
      tick;

      for (int i = 1; i <= 3; i++) push(i, 5, 7, 9);
      chk("t1_token_pre", 32'(token), 32'd0);
      set_freeze(1'b1);
      chk("t1_token_rise", 32'(token), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         read_word(-1, 1'b0, w, tok);
         chk($sformatf("t1_word%0d", i), 32'(w), 32'(wd(i, 5, 7, 9)));
         chk($sformatf("t1_tok%0d", i), 32'(tok), 32'(i != 3));
      end
      set_freeze(1'b0);

      push(10, 300, 33, 44);
      push(11, 301, 34, 45);
      set_freeze(1'b1);
      chk("t2_token", 32'(token), 32'd1);
      read_word(5, 1'b0, w, tok);
      chk("t2_word_a", 32'(w), 32'(wd(10, 300, 33, 44)));
      chk("t2_tok_a", 32'(tok), 32'd1);
      read_word(-1, 1'b0, w, tok);
      chk("t2_word_b", 32'(w), 32'(wd(11, 301, 34, 45)));
      chk("t2_tok_b", 32'(tok), 32'd0);
      read = 1'b1;
      tick;
      read = 1'b0;
      chk("t2_idle_busy", 32'(busy), 32'd0);
      chk("t2_perr", 32'(perr_cnt), 32'd2);
      set_freeze(1'b0);

      for (int i = 0; i < 20; i++) begin
         set_hit(i, i * 3, i, 63 - i);
         hit_valid = 1'b1;
         tick;
         if (i == 14) chk("t3_ready15", 32'(hit_ready), 32'd1);
         if (i == 15) chk("t3_ready16", 32'(hit_ready), 32'd0);
      end
      hit_valid = 1'b0;
      chk("t3_drop", 32'(drop_cnt), 32'd4);
      set_freeze(1'b1);
      chk("t3_token", 32'(token), 32'd1);
      set_hit(63, 511, 1, 2);
      read_word(-1, 1'b1, w, tok);
      chk("t3_word", 32'(w), 32'(wd(0, 0, 0, 63)));
      chk("t3_drop_fullpop", 32'(drop_cnt), 32'd4);
      chk("t3_ready_fullpop", 32'(hit_ready), 32'd0);

      set_freeze(1'b0);
      set_freeze(1'b1);
      chk("t4_token", 32'(token), 32'd1);
      read = 1'b1;
      tick;
      read = 1'b0;
      tick;
      repeat (13) tick;
      chk("t4_mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick;
      chk("t4_rst_data", 32'(data_out), 32'd0);
      chk("t4_rst_busy", 32'(busy), 32'd0);
      chk("t4_rst_token", 32'(token), 32'd0);
      chk("t4_rst_ready", 32'(hit_ready), 32'd1);
      rst_n = 1'b1;
      push(20, 100, 3, 4);
      chk("t5_token_outrst", 32'(token), 32'd0);
      tick;
      chk("t5_token_held", 32'(token), 32'd0);
      read = 1'b1;
      tick;
      read = 1'b0;
      chk("t5_perr", 32'(perr_cnt), 32'd1);
      set_freeze(1'b0);
      set_freeze(1'b1);
      chk("t5_token_one", 32'(token), 32'd1);
      push(21, 101, 5, 6);
      push(22, 102, 7, 8);
      read_word(-1, 1'b0, w, tok);
      chk("t5_word_a", 32'(w), 32'(wd(20, 100, 3, 4)));
      chk("t5_tok_a", 32'(tok), 32'd0);
      chk("t5_token_after", 32'(token), 32'd0);
      set_freeze(1'b0);
      set_freeze(1'b1);
      chk("t5_token_refreeze", 32'(token), 32'd1);
      read_word(-1, 1'b0, w, tok);
      chk("t5_word_b", 32'(w), 32'(wd(21, 101, 5, 6)));
      chk("t5_tok_b", 32'(tok), 32'd1);
      read_word(-1, 1'b0, w, tok);
      chk("t5_word_c", 32'(w), 32'(wd(22, 102, 7, 8)));
      chk("t5_tok_c", 32'(tok), 32'd0);

      freeze = 1'b0;
      rst_n = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      push(45, 511, 62, 1);
      set_freeze(1'b1);
      chk("t6_token", 32'(token1), 32'd1);
      read1 = 1'b1;
      tick;
      read1 = 1'b0;
      chk("t6_msb_busy", 32'(busy1), 32'd1);
      w = '0;
      n = 0;
      for (int i = 0; i < 40 && busy1; i++) begin
         w = {w[25:0], data_out1};
         n++;
         tick;
      end
      chk("t6_busy_cycles", 32'(n), 32'd27);
      chk("t6_word", 32'(w), 32'(wd(45, 511, 62, 1)));
      chk("t6_end_data", 32'(data_out1), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
